// File: rtl/remote_cmd_sequencer_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | remote_cmd_sequencer_if: host push port plus RemoteComm command link.    |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
interface remote_cmd_sequencer_if #(
  parameter int CMD_W  = 8,
  parameter int DATA_W = 16
) ();
  logic              push;
  logic [CMD_W-1:0]  push_cmd;
  logic [DATA_W-1:0] push_data;
  logic              full;
  logic              empty;
  logic              overflow;
  logic              send_cmd;
  logic [CMD_W-1:0]  cmd;
  logic [DATA_W-1:0] data;
  logic              cmd_sent;
  logic              resp_rdy;
  logic [7:0]        resp;
  logic              clr_resp_rdy;
  logic              done;
  logic              err;
  logic [1:0]        err_code;
  logic [15:0]       ack_cnt;

  modport master (
    input  push, push_cmd, push_data, cmd_sent, resp_rdy, resp,
    output full, empty, overflow, send_cmd, cmd, data, clr_resp_rdy,
           done, err, err_code, ack_cnt
  );

  modport slave (
    output push, push_cmd, push_data, cmd_sent, resp_rdy, resp,
    input  full, empty, overflow, send_cmd, cmd, data, clr_resp_rdy,
           done, err, err_code, ack_cnt
  );
endinterface
`default_nettype wire

// File: rtl/remote_cmd_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | remote_cmd_sequencer: FIFO-queued command issuer for RemoteComm with     |
// | response timeout and ACK check; CMDSEQ_RETRY_EN enables re-sends.        |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module remote_cmd_sequencer #(
  parameter int         CMD_W       = 8,
  parameter int         DATA_W      = 16,
  parameter int         DEPTH       = 8,
  parameter int         TIMEOUT_CYC = 1000000,
  parameter logic [7:0] ACK_CODE    = 8'hA5,
  parameter int         MAX_RETRY   = 2
) (
  input  wire logic              clk,
  input  wire logic              rst,
  remote_cmd_sequencer_if.master bus
);
  localparam int            AW         = $clog2(DEPTH);
  localparam int            TW         = $clog2(TIMEOUT_CYC + 1);
  localparam int            EW         = CMD_W + DATA_W;
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYC - 1);
  localparam logic [TW-1:0] TIMER_MAX  = '1;
  localparam logic [AW:0]   FIFO_DEPTH = (AW + 1)'(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_SEND      = 3'd1,
    S_WAIT_SENT = 3'd2,
    S_WAIT_RESP = 3'd3,
    S_CHECK     = 3'd4,
    S_FAIL      = 3'd5
  } state_t;

  state_t            state_q, state_d;
  logic [EW-1:0]     mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]       count_q, count_d;
  logic              overflow_q, overflow_d;
  logic [CMD_W-1:0]  cmd_q, cmd_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [TW-1:0]     timer_q, timer_d;
  logic [7:0]        resp_q, resp_d;
  logic [15:0]       ack_cnt_q, ack_cnt_d;
  logic [1:0]        err_code_q, err_code_d;

  logic       fifo_full, fifo_pop, fifo_wr;
  logic       send_cmd, clr_resp_rdy, done, err;
  logic       fail_now, retry_ok;
  logic [1:0] fail_code;

  assign fifo_full = (count_q == FIFO_DEPTH);
  assign fifo_pop  = (state_q == S_IDLE) && (count_q != '0);
  assign fifo_wr   = bus.push && (!fifo_full || fifo_pop);

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q + (AW + 1)'(fifo_wr) - (AW + 1)'(fifo_pop);
    overflow_d = overflow_q | (bus.push && fifo_full && !fifo_pop);
    if (fifo_wr)  wr_ptr_d = wr_ptr_q + 1'b1;
    if (fifo_pop) rd_ptr_d = rd_ptr_q + 1'b1;
  end

  // Storage carries no reset; occupancy is governed entirely by the pointers.
  always_ff @(posedge clk) begin
    if (fifo_wr) mem_q[wr_ptr_q] <= {bus.push_cmd, bus.push_data};
  end

  always_comb begin
    state_d      = state_q;
    cmd_d        = cmd_q;
    data_d       = data_q;
    timer_d      = timer_q;
    resp_d       = resp_q;
    ack_cnt_d    = ack_cnt_q;
    err_code_d   = err_code_q;
    send_cmd     = 1'b0;
    clr_resp_rdy = 1'b0;
    done         = 1'b0;
    err          = 1'b0;
    fail_now     = 1'b0;
    fail_code    = 2'b00;
    unique case (state_q)
      S_IDLE: begin
        if (fifo_pop) begin
          {cmd_d, data_d} = mem_q[rd_ptr_q];
          state_d         = S_SEND;
        end
      end
      S_SEND: begin
        send_cmd = 1'b1;
        state_d  = S_WAIT_SENT;
      end
      S_WAIT_SENT: begin
        if (bus.resp_rdy) begin
          resp_d  = bus.resp;
          state_d = S_CHECK;
        end else if (bus.cmd_sent) begin
          timer_d = '0;
          state_d = S_WAIT_RESP;
        end
      end
      S_WAIT_RESP: begin
        if (timer_q != TIMER_MAX) timer_d = timer_q + 1'b1;
        // A response arriving on the timeout cycle still wins.
        if (bus.resp_rdy) begin
          resp_d  = bus.resp;
          state_d = S_CHECK;
        end else if (timer_q == TIMER_LAST) begin
          fail_now  = 1'b1;
          fail_code = 2'b01;
        end
      end
      S_CHECK: begin
        clr_resp_rdy = 1'b1;
        if (resp_q == ACK_CODE) begin
          done      = 1'b1;
          ack_cnt_d = ack_cnt_q + 16'd1;
          state_d   = S_IDLE;
        end else begin
          fail_now  = 1'b1;
          fail_code = 2'b10;
        end
      end
      S_FAIL: begin
        err     = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (fail_now) begin
      if (retry_ok) begin
        state_d = S_SEND;
      end else begin
        state_d    = S_FAIL;
        err_code_d = fail_code;
      end
    end
  end

`ifdef CMDSEQ_RETRY_EN
  localparam int RW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
  logic [RW-1:0] retry_q, retry_d;

  assign retry_ok = (int'(retry_q) < MAX_RETRY);

  always_comb begin
    retry_d = retry_q;
    if (fifo_pop)                 retry_d = '0;
    else if (fail_now && retry_ok) retry_d = retry_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) retry_q <= '0;
    else     retry_q <= retry_d;
  end
`else
  logic unused_max_retry;
  assign retry_ok         = 1'b0;
  assign unused_max_retry = (MAX_RETRY != 0);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      cmd_q      <= '0;
      data_q     <= '0;
      timer_q    <= '0;
      resp_q     <= '0;
      ack_cnt_q  <= '0;
      err_code_q <= 2'b00;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      cmd_q      <= cmd_d;
      data_q     <= data_d;
      timer_q    <= timer_d;
      resp_q     <= resp_d;
      ack_cnt_q  <= ack_cnt_d;
      err_code_q <= err_code_d;
    end
  end

  assign bus.full         = fifo_full;
  assign bus.empty        = (count_q == '0) && (state_q == S_IDLE);
  assign bus.overflow     = overflow_q;
  assign bus.send_cmd     = send_cmd;
  assign bus.cmd          = cmd_q;
  assign bus.data         = data_q;
  assign bus.clr_resp_rdy = clr_resp_rdy;
  assign bus.done         = done;
  assign bus.err          = err;
  assign bus.err_code     = err ? err_code_q : 2'b00;
  assign bus.ack_cnt      = ack_cnt_q;
endmodule
`default_nettype wire

// File: tb/tb_remote_cmd_sequencer.sv
`default_nettype none
// Bench for remote_cmd_sequencer: RemoteComm responder model plus a scoreboard
// of the {cmd,data} pairs expected on each send_cmd strobe.
module tb_remote_cmd_sequencer;
  localparam int CMD_W       = 8;
  localparam int DATA_W      = 16;
  localparam int DEPTH       = 8;
  localparam int TIMEOUT_CYC = 100;
  localparam int MAX_RETRY   = 2;
`ifdef CMDSEQ_RETRY_EN
  localparam int N_TRY = MAX_RETRY + 1;
`else
  localparam int N_TRY = 1;
`endif
  localparam int M_ACK = 0, M_STALL = 1, M_NORESP = 2, M_BAD = 3, M_COLLIDE = 4;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0, checks = 0, errors = 0, mode = M_ACK;
  int   n_send = 0, n_done = 0, n_err = 0, n_clr = 0, n_sent = 0;
  int   last_send_cyc = 0, last_err_cyc = 0, last_done_cyc = 0, sent_cyc = 0, push_cyc = 0;
  int   sent_dly = 0, resp_dly = 0;
  bit   issued = 1'b0;
  logic [1:0]  last_err_code = 2'b00;
  logic [15:0] exp_ack = 16'd0;
  logic [CMD_W+DATA_W-1:0] exp_q [$];

  remote_cmd_sequencer_if #(.CMD_W(CMD_W), .DATA_W(DATA_W)) bus ();

  remote_cmd_sequencer #(
    .CMD_W(CMD_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .TIMEOUT_CYC(TIMEOUT_CYC),
    .ACK_CODE(8'hA5), .MAX_RETRY(MAX_RETRY)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // RemoteComm model: cmd_sent 2 cycles after send_cmd, response per mode.
  initial begin
    bus.cmd_sent = 1'b0;
    bus.resp_rdy = 1'b0;
    bus.resp     = 8'h00;
    forever begin
      @(posedge clk); #1;
      bus.cmd_sent = 1'b0;
      if (rst) begin
        bus.resp_rdy = 1'b0;
        sent_dly = 0; resp_dly = 0; issued = 1'b0;
      end else begin
        if (bus.clr_resp_rdy) bus.resp_rdy = 1'b0;
        if (resp_dly > 0) begin
          resp_dly--;
          if (resp_dly == 0) begin
            bus.resp_rdy = 1'b1;
            bus.resp     = (mode == M_BAD) ? 8'h5A : 8'hA5;
          end
        end
        if (sent_dly > 0) begin
          sent_dly--;
          if (sent_dly == 0) begin
            bus.cmd_sent = 1'b1;
            sent_cyc = cyc;
            n_sent++;
            if (mode == M_ACK || mode == M_BAD) resp_dly = 2;
            else if (mode == M_COLLIDE)         resp_dly = TIMEOUT_CYC;
          end
        end
        if (bus.send_cmd) issued = 1'b1;
        if (issued && mode != M_STALL) begin
          issued = 1'b0;
          sent_dly = 2;
        end
      end
    end
  end

  // Monitor: scoreboard pop on every send_cmd, pulse counting.
  initial begin
    logic [CMD_W+DATA_W-1:0] e;
    forever begin
      @(posedge clk); #1;
      if (!rst) begin
        if (bus.send_cmd) begin
          n_send++;
          last_send_cyc = cyc;
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL scoreboard: unexpected send_cmd cmd=%h data=%h, want none", bus.cmd, bus.data);
          end else begin
            e = exp_q.pop_front();
            if ({bus.cmd, bus.data} !== e) begin
              errors++;
              $display("FAIL scoreboard: got cmd=%h data=%h, want cmd=%h data=%h",
                       bus.cmd, bus.data, e[CMD_W+DATA_W-1:DATA_W], e[DATA_W-1:0]);
            end
          end
        end
        if (bus.done) begin n_done++; last_done_cyc = cyc; end
        if (bus.err) begin n_err++; last_err_cyc = cyc; last_err_code = bus.err_code; end
        if (bus.clr_resp_rdy) n_clr++;
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic do_push(input logic [CMD_W-1:0] c, input logic [DATA_W-1:0] d, input bit accept);
    bus.push = 1'b1; bus.push_cmd = c; bus.push_data = d;
    push_cyc = cyc;
    if (accept) exp_q.push_back({c, d});
    @(posedge clk); #1;
    bus.push = 1'b0;
  endtask

  task automatic wait_empty(input int budget, input string name);
    int n = 0;
    while (bus.empty !== 1'b1 && n < budget) begin @(posedge clk); #1; n++; end
    checks++;
    if (bus.empty !== 1'b1) begin
      errors++;
      $display("FAIL %s wait: empty=%b after %0d cycles, want 1", name, bus.empty, n);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    logic [48:0] obs, exp_v;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    exp_v = {1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 16'h0000, 16'h0000};
    obs = {bus.send_cmd, bus.done, bus.err, bus.err_code, bus.clr_resp_rdy, bus.full,
           bus.overflow, bus.empty, bus.cmd, bus.data, bus.ack_cnt};
    checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL reset outputs: got %h, want %h", obs, exp_v); end
    rst = 1'b0;
  endtask

  task automatic test_single();
    int b_send = n_send, b_done = n_done, b_clr = n_clr, b_err = n_err, t;
    mode = M_ACK;
    do_push(8'h05, 16'h0666, 1'b1);
    t = push_cyc;
    wait_empty(60, "single");
    exp_ack = exp_ack + 16'd1;
    checks++;
    if (last_send_cyc !== t + 2) begin errors++; $display("FAIL single latency: send at %0d, want %0d", last_send_cyc, t + 2); end
    checks++;
    if (n_send - b_send !== 1) begin errors++; $display("FAIL single sends: got %0d, want 1", n_send - b_send); end
    checks++;
    if (n_clr - b_clr !== 1) begin errors++; $display("FAIL single clr_resp_rdy: got %0d, want 1", n_clr - b_clr); end
    checks++;
    if (n_done - b_done !== 1 || n_err != b_err) begin
      errors++; $display("FAIL single done/err: got %0d/%0d, want 1/0", n_done - b_done, n_err - b_err);
    end
    checks++;
    if (bus.ack_cnt !== exp_ack) begin errors++; $display("FAIL single ack_cnt: got %0d, want %0d", bus.ack_cnt, exp_ack); end
  endtask

  task automatic test_fill_overflow();
    int b_done = n_done, b_err = n_err;
    mode = M_STALL;
    for (int i = 0; i < 10; i++) begin
      do_push(8'(8'h02 + i), 16'(16'h1000 + i), i < 9);
      if (i == 7) begin
        checks++;
        if (bus.full !== 1'b0) begin errors++; $display("FAIL fill full after 8: got %b, want 0", bus.full); end
      end
      if (i == 8) begin
        checks++;
        if (bus.full !== 1'b1 || bus.overflow !== 1'b0) begin
          errors++; $display("FAIL fill full/overflow after 9: got %b/%b, want 1/0", bus.full, bus.overflow);
        end
      end
    end
    checks++;
    if (bus.overflow !== 1'b1) begin errors++; $display("FAIL overflow after 10th push: got %b, want 1", bus.overflow); end
    mode = M_ACK;
    wait_empty(2000, "fill");
    exp_ack = exp_ack + 16'd9;
    checks++;
    if (n_done - b_done !== 9 || n_err != b_err) begin
      errors++; $display("FAIL fill done/err: got %0d/%0d, want 9/0", n_done - b_done, n_err - b_err);
    end
    checks++;
    if (bus.ack_cnt !== exp_ack || bus.overflow !== 1'b1) begin
      errors++; $display("FAIL fill ack_cnt/overflow: got %0d/%b, want %0d/1", bus.ack_cnt, bus.overflow, exp_ack);
    end
  endtask

  task automatic test_timeout();
    int b_send = n_send, b_done = n_done, b_err = n_err, b_clr = n_clr;
    mode = M_NORESP;
    for (int i = 1; i < N_TRY; i++) exp_q.push_back({8'h11, 16'h2222});
    do_push(8'h11, 16'h2222, 1'b1);
    wait_empty(1000, "timeout");
    checks++;
    if (n_send - b_send !== N_TRY) begin errors++; $display("FAIL timeout sends: got %0d, want %0d", n_send - b_send, N_TRY); end
    checks++;
    if (n_err - b_err !== 1 || last_err_code !== 2'b01) begin
      errors++; $display("FAIL timeout err/code: got %0d/%b, want 1/01", n_err - b_err, last_err_code);
    end
    // Last WAIT_RESP cycle has timer==TIMEOUT_CYC-1; the FAIL pulse follows it.
    checks++;
    if (last_err_cyc - sent_cyc !== TIMEOUT_CYC + 1) begin
      errors++; $display("FAIL timeout timing: err %0d cycles after cmd_sent, want %0d", last_err_cyc - sent_cyc, TIMEOUT_CYC + 1);
    end
    checks++;
    if (n_done != b_done || n_clr != b_clr || bus.ack_cnt !== exp_ack) begin
      errors++; $display("FAIL timeout side effects: done %0d clr %0d ack %0d, want 0 0 %0d",
                         n_done - b_done, n_clr - b_clr, bus.ack_cnt, exp_ack);
    end
  endtask

  task automatic test_bad_resp();
    int b_done = n_done, b_err = n_err, b_clr = n_clr;
    mode = M_BAD;
    for (int i = 1; i < N_TRY; i++) exp_q.push_back({8'h21, 16'hBEEF});
    do_push(8'h21, 16'hBEEF, 1'b1);
    wait_empty(200, "bad_resp");
    checks++;
    if (n_clr - b_clr !== N_TRY) begin errors++; $display("FAIL bad_resp clr: got %0d, want %0d", n_clr - b_clr, N_TRY); end
    checks++;
    if (n_err - b_err !== 1 || last_err_code !== 2'b10) begin
      errors++; $display("FAIL bad_resp err/code: got %0d/%b, want 1/10", n_err - b_err, last_err_code);
    end
    checks++;
    if (n_done != b_done || bus.ack_cnt !== exp_ack) begin
      errors++; $display("FAIL bad_resp done/ack: got %0d/%0d, want 0/%0d", n_done - b_done, bus.ack_cnt, exp_ack);
    end
  endtask

  task automatic test_reset_mid();
    int b_send = n_send, b_done = n_done, b_err = n_err, b_sent = n_sent, k = 0;
    logic [48:0] obs, exp_v;
    mode = M_NORESP;
    do_push(8'h33, 16'h3333, 1'b1);
    do_push(8'h44, 16'h4444, 1'b1);
    while (n_sent == b_sent && k < 50) begin @(posedge clk); #1; k++; end
    checks++;
    if (n_sent == b_sent) begin errors++; $display("FAIL reset_mid wait: cmd_sent count %0d, want >%0d", n_sent, b_sent); end
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    exp_v = {1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 16'h0000, 16'h0000};
    obs = {bus.send_cmd, bus.done, bus.err, bus.err_code, bus.clr_resp_rdy, bus.full,
           bus.overflow, bus.empty, bus.cmd, bus.data, bus.ack_cnt};
    checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL reset_mid outputs: got %h, want %h", obs, exp_v); end
    rst = 1'b0;
    exp_q.delete();
    exp_ack = 16'd0;
    repeat (8) @(posedge clk);
    #1;
    checks++;
    if (n_send - b_send !== 1 || n_done != b_done || n_err != b_err || bus.empty !== 1'b1) begin
      errors++; $display("FAIL reset_mid after: sends %0d done %0d err %0d empty %b, want 1 0 0 1",
                         n_send - b_send, n_done - b_done, n_err - b_err, bus.empty);
    end
  endtask

  task automatic test_collide();
    int b_done = n_done, b_err = n_err;
    mode = M_COLLIDE;
    do_push(8'h55, 16'hA5A5, 1'b1);
    wait_empty(300, "collide");
    exp_ack = exp_ack + 16'd1;
    checks++;
    if (n_done - b_done !== 1 || n_err != b_err) begin
      errors++; $display("FAIL collide done/err: got %0d/%0d, want 1/0", n_done - b_done, n_err - b_err);
    end
    checks++;
    if (last_done_cyc - sent_cyc !== TIMEOUT_CYC + 1) begin
      errors++; $display("FAIL collide timing: done %0d cycles after cmd_sent, want %0d", last_done_cyc - sent_cyc, TIMEOUT_CYC + 1);
    end
    checks++;
    if (bus.ack_cnt !== exp_ack) begin errors++; $display("FAIL collide ack_cnt: got %0d, want %0d", bus.ack_cnt, exp_ack); end
  endtask

  initial begin
    rst = 1'b1;
    bus.push = 1'b0;
    bus.push_cmd = '0;
    bus.push_data = '0;
    test_reset();
    test_single();
    test_fill_overflow();
    test_timeout();
    test_bad_resp();
    test_reset_mid();
    test_collide();
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL scoreboard leftover: got %0d entries, want 0", exp_q.size()); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
